// File: rtl/filter_median_pkg.sv
// rtl/filter_median_pkg.sv - shared types and constants for the median stream controller
package filter_median_pkg;

  localparam int MEDIAN_7X7_LATENCY = 12;
  localparam int PIX_DWIDTH = 8;

  typedef logic [PIX_DWIDTH-1:0] pix_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  function automatic int median_idx(input int kernel_size);
    return kernel_size / 2;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - show-ahead synchronous FIFO with full/empty/count
module sync_fifo_fwft #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  // Head is forced to zero when empty so the output is defined straight out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/filter_median_stream_ctrl.sv
// rtl/filter_median_stream_ctrl.sv - valid/ready wrapper around a fixed-latency median sorting entity
module filter_median_stream_ctrl
  import filter_median_pkg::*;
#(
  parameter int KERNEL_SIZE = 49,
  parameter int DWIDTH      = 8,
  parameter int LATENCY     = MEDIAN_7X7_LATENCY,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DWIDTH*KERNEL_SIZE-1:0] s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DWIDTH-1:0]             m_data,
  input  logic                          flush,
  output logic                          flush_done,
  output logic [DWIDTH*KERNEL_SIZE-1:0] ent_xi,
  input  logic [DWIDTH*KERNEL_SIZE-1:0] ent_xo
);

  localparam int MID   = median_idx(KERNEL_SIZE);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [OCC_W-1:0]  occ;
  logic [LATENCY:0]  vld_sr;
  logic              accept;
  logic              pop;
  logic              run;
  logic              fifo_full;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_count;
  logic              ovf_err;
  logic              unused_ok;

  // occ counts windows in flight plus queued results, so admission alone
  // guarantees the FIFO has room when a result emerges from the entity.
  assign s_ready = ~rst & run & (occ < OCC_W'(FIFO_DEPTH));
  assign accept  = s_valid & s_ready;
  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_xi  <= '0;
      vld_sr  <= '0;
      occ     <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (accept) ent_xi <= s_data;
      vld_sr <= {vld_sr[LATENCY-1:0], accept};
      case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (vld_sr[LATENCY] & fifo_full) ovf_err <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_sr[LATENCY]),
    .wr_data (ent_xo[MID*DWIDTH +: DWIDTH]),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (occ == '0) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    run        = (state == RUN);
    flush_done = (state == DONE);
  end

  // Only the median lane of the sorted vector is consumed; ovf_err is a debug probe.
  assign unused_ok = ^{ent_xo, ovf_err, fifo_count};

endmodule

// File: tb/tb_filter_median_stream_ctrl.sv
// tb/tb_filter_median_stream_ctrl.sv - randomized scoreboard bench for the median stream controller
`timescale 1ns/1ps
module tb_filter_median_stream_ctrl;
  import filter_median_pkg::*;

  localparam int KS  = 49;
  localparam int DW  = 8;
  localparam int LAT = 12;
  localparam int FD  = 16;
  localparam int WW  = KS * DW;
  localparam int MID = KS / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [WW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          flush = 1'b0;
  logic          flush_done;
  logic [WW-1:0] ent_xi;
  logic [WW-1:0] ent_xo;
  logic [WW-1:0] ent_pipe [LAT];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  int   n_fd = 0;
  int   p_first = -1;
  int   p_last = -1;
  pix_t exp_q [$];
  pix_t e_med;

  filter_median_stream_ctrl #(
    .KERNEL_SIZE (KS),
    .DWIDTH      (DW),
    .LATENCY     (LAT),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .flush      (flush),
    .flush_done (flush_done),
    .ent_xi     (ent_xi),
    .ent_xo     (ent_xo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WW-1:0] sort_window(input logic [WW-1:0] w);
    pix_t a [KS];
    pix_t t;
    logic [WW-1:0] r;
    for (int k = 0; k < KS; k++) a[k] = w[k*DW +: DW];
    for (int i = 1; i < KS; i++) begin
      int j;
      t = a[i];
      j = i;
      while (j > 0 && a[j-1] > t) begin
        a[j] = a[j-1];
        j--;
      end
      a[j] = t;
    end
    for (int k = 0; k < KS; k++) r[k*DW +: DW] = a[k];
    return r;
  endfunction

  // Behavioural entity: sort, then a fixed delay line.
  always @(posedge clk) begin
    ent_pipe[0] <= sort_window(ent_xi);
    for (int i = 1; i < LAT; i++) ent_pipe[i] <= ent_pipe[i-1];
  end
  assign ent_xo = ent_pipe[LAT-1];

  // Median by rank counting: the pixel with at most MID smaller and more than MID not larger.
  function automatic pix_t ref_median(input logic [WW-1:0] w);
    pix_t p;
    pix_t q;
    int   lt;
    int   le;
    for (int k = 0; k < KS; k++) begin
      p = w[k*DW +: DW];
      lt = 0;
      le = 0;
      for (int j = 0; j < KS; j++) begin
        q = w[j*DW +: DW];
        if (q < p) lt++;
        if (q <= p) le++;
      end
      if (lt <= MID && le > MID) return p;
    end
    return '0;
  endfunction

  function automatic logic [WW-1:0] rand_window();
    logic [WW-1:0] w;
    for (int k = 0; k < KS; k++) w[k*DW +: DW] = DW'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic check_vec(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: handshakes are observed mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (s_valid && s_ready) begin
        exp_q.push_back(ref_median(s_data));
        n_acc++;
      end
      if (m_valid && m_ready) begin
        n_pop++;
        if (p_first < 0) p_first = cyc;
        p_last = cyc;
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL pop_underflow: observed queue size %0d expected nonzero", exp_q.size());
        end
        if (exp_q.size() != 0) begin
          e_med = exp_q.pop_front();
          check_vec("median", WW'(m_data), WW'(e_med));
        end
      end
      if (flush_done) n_fd++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [WW-1:0] w, input string tag);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && guard < 200) begin
      tick();
      guard++;
    end
    check_int({tag, "_accept_wait"}, int'(guard < 200), 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && guard < 300) begin
      tick();
      guard++;
    end
    check_int({tag, "_drained"}, exp_q.size(), 0);
    check_bit({tag, "_m_valid_idle"}, m_valid, 1'b0);
  endtask

  task automatic check_latency(input logic [WW-1:0] w, input string tag);
    int early;
    early = 0;
    m_ready = 1'b1;
    send_one(w, tag);
    check_vec({tag, "_ent_xi"}, ent_xi, w);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (m_valid !== 1'b0) early++;
    end
    check_int({tag, "_early_valid"}, early, 0);
    tick();
    check_bit({tag, "_valid_at_13"}, m_valid, 1'b1);
    check_vec({tag, "_data_at_13"}, WW'(m_data), WW'(ref_median(w)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w;
    int a0, p0, f0, bad, acc, guard, zero_at, fd_at;
    logic sr_after;
    logic hs;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_bit("rst_s_ready", s_ready, 1'b0);
    check_bit("rst_m_valid", m_valid, 1'b0);
    check_vec("rst_m_data", WW'(m_data), '0);
    check_bit("rst_flush_done", flush_done, 1'b0);
    check_vec("rst_ent_xi", ent_xi, '0);
    rst = 1'b0;
    #1;
    check_bit("post_rst_s_ready", s_ready, 1'b1);

    // Single descending window: median is 24
    for (int k = 0; k < KS; k++) w[k*DW +: DW] = DW'(48 - k);
    p0 = n_pop;
    f0 = n_fd;
    check_latency(w, "single");
    check_vec("single_median_24", WW'(m_data), WW'(24));
    repeat (20) tick();
    check_int("single_pop_count", n_pop - p0, 1);
    check_int("single_no_flush_done", n_fd - f0, 0);

    // Back-to-back streaming
    m_ready = 1'b1;
    p_first = -1;
    a0 = n_acc;
    p0 = n_pop;
    bad = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s_data = rand_window();
      if (s_ready !== 1'b1) bad++;
      tick();
    end
    s_valid = 1'b0;
    wait_drain("stream");
    check_int("stream_ready_drops", bad, 0);
    check_int("stream_accepted", n_acc - a0, 1000);
    check_int("stream_popped", n_pop - p0, 1000);
    check_int("stream_output_span", p_last - p_first + 1, 1000);

    // Full stall
    m_ready = 1'b0;
    s_valid = 1'b1;
    a0 = n_acc;
    repeat (40) begin
      s_data = rand_window();
      tick();
    end
    check_int("stall_accepted", n_acc - a0, FD);
    check_bit("stall_s_ready", s_ready, 1'b0);
    check_bit("stall_m_valid", m_valid, 1'b1);
    p0 = n_pop;
    m_ready = 1'b1;
    tick();
    check_bit("stall_resume_s_ready", s_ready, 1'b1);
    s_valid = 1'b0;
    wait_drain("stall");
    check_int("stall_popped", n_pop - p0, FD);
    check_bit("stall_ovf", dut.ovf_err, 1'b0);

    // Random backpressure
    acc = 0;
    guard = 0;
    a0 = n_acc;
    s_valid = 1'b0;
    s_data = rand_window();
    while (acc < 5000 && guard < 40000) begin
      if (!s_valid) s_valid = ($urandom_range(0, 99) < 70);
      m_ready = ($urandom_range(0, 99) < 30);
      #1;
      hs = s_valid & s_ready;
      tick();
      guard++;
      if (hs) begin
        acc++;
        s_data = rand_window();
        s_valid = ($urandom_range(0, 99) < 70);
      end
    end
    s_valid = 1'b0;
    check_int("bp_accepted", n_acc - a0, 5000);
    wait_drain("bp");
    check_bit("bp_ovf", dut.ovf_err, 1'b0);

    // Flush with 5 windows in flight
    m_ready = 1'b1;
    p0 = n_pop;
    f0 = n_fd;
    s_valid = 1'b1;
    repeat (5) begin
      s_data = rand_window();
      tick();
    end
    s_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_bit("flush_s_ready_low", s_ready, 1'b0);
    zero_at = -1;
    fd_at = -1;
    bad = 0;
    sr_after = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (zero_at < 0 && exp_q.size() == 0) zero_at = k;
      if (fd_at < 0 && flush_done === 1'b1) fd_at = k;
      if (fd_at >= 0 && k == fd_at + 1) sr_after = s_ready;
      if ((fd_at < 0 || fd_at == k) && s_ready !== 1'b0) bad++;
      tick();
    end
    check_int("flush_popped", n_pop - p0, 5);
    check_int("flush_done_count", n_fd - f0, 1);
    check_int("flush_done_timing", fd_at - zero_at, 1);
    check_int("flush_ready_during_drain", bad, 0);
    check_bit("flush_ready_after", sr_after, 1'b1);

    // Flush on an empty pipeline
    f0 = n_fd;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_bit("eflush_done_c1", flush_done, 1'b0);
    check_bit("eflush_s_ready_c1", s_ready, 1'b0);
    tick();
    check_bit("eflush_done_c2", flush_done, 1'b1);
    tick();
    check_bit("eflush_done_c3", flush_done, 1'b0);
    check_bit("eflush_s_ready_c3", s_ready, 1'b1);
    check_int("eflush_done_count", n_fd - f0, 1);

    // Reset with windows both queued and in flight
    m_ready = 1'b0;
    s_valid = 1'b1;
    a0 = n_acc;
    repeat (8) begin
      s_data = rand_window();
      tick();
    end
    s_valid = 1'b0;
    check_int("mrst_accepted", n_acc - a0, 8);
    repeat (10) tick();
    check_bit("mrst_pre_m_valid", m_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_bit("mrst_m_valid", m_valid, 1'b0);
    check_vec("mrst_m_data", WW'(m_data), '0);
    check_bit("mrst_s_ready", s_ready, 1'b1);
    p0 = n_pop;
    m_ready = 1'b1;
    repeat (30) tick();
    check_int("mrst_no_stale", n_pop - p0, 0);
    w = rand_window();
    check_latency(w, "mrst_new");
    repeat (5) tick();
    check_int("mrst_new_popped", n_pop - p0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filter_median_stream_ctrl.md
# filter_median_stream_ctrl

Stream controller that drives the free-running 7x7 median sorting entity (`filter_median_7x7_entity`, no enable, fixed latency) from a valid/ready pixel-window stream. It registers each accepted 49-pixel window into the entity and tracks it through the pipeline with a valid shift register. It captures the median element (the sorted output's middle index) into an output FIFO and admits new windows only when FIFO space is guaranteed. Sits between the window/line-buffer generator and the video output formatter.

## Interface
- `KERNEL_SIZE`, 49: pixels per window; odd.
- `DWIDTH`, 8: pixel width.
- `LATENCY`, 12: entity clocks from `ent_xi` change to matching `ent_xo`; must equal the instantiated entity's latency.
- `FIFO_DEPTH`, 16: output FIFO entries; must be ≥ LATENCY+2.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `s_valid`  in  1: input window valid.
- `s_ready`  out  1: window accepted when `s_valid & s_ready`.
- `s_data`  in  DWIDTH*KERNEL_SIZE: window; pixel k at bits [k*DWIDTH +: DWIDTH].
- `m_valid`  out  1: median valid.
- `m_ready`  in  1: median consumed when `m_valid & m_ready`.
- `m_data`  out  DWIDTH: median pixel.
- `flush`  in  1: pulse; stop accepting and drain.
- `flush_done`  out  1: one-cycle pulse when drain completes.
- `ent_xi`  out  DWIDTH*KERNEL_SIZE: to entity `xi`.
- `ent_xo`  in  DWIDTH*KERNEL_SIZE: from entity `xo`, sorted ascending (index 0 smallest).

## Operation
- `occ` counter (0..FIFO_DEPTH): windows in flight plus FIFO entries. +1 on accept, −1 on output pop, both in the same cycle → unchanged.
- `s_ready = (state==RUN) & (occ < FIFO_DEPTH)`, decoded from registers only, with no combinational path from `m_ready`.
- On accept, `ent_xi <= s_data` and `vld_sr[0] <= 1`. Otherwise `ent_xi` holds its value and `vld_sr[0] <= 0`.
- `vld_sr` is LATENCY+1 bits and shifts every cycle. When `vld_sr[LATENCY]` is 1, write `ent_xo[(KERNEL_SIZE/2)*DWIDTH +: DWIDTH]` into the FIFO.
- Because of the `occ` admission, a FIFO write never finds the FIFO full. A write to a full FIFO sets an internal sticky `ovf_err` flag for verification; this is never expected.
- FIFO is show-ahead: `m_valid` = not empty, and `m_data` = head entry.
- FSM:
  - RUN → DRAIN on `flush`.
  - DRAIN → DONE when `occ==0`.
  - DONE → RUN unconditionally after 1 cycle, with `flush_done=1` in DONE.
  - `flush` in DRAIN or DONE is ignored.
  - If `flush` arrives while `occ==0`, DRAIN lasts 1 cycle.
- In DRAIN, `s_ready=0`, and in-flight windows and FIFO contents still emerge normally.

## Timing
- Reset values: `s_ready=0` during reset, 1 the first cycle after; `m_valid=0`; `m_data=0`; `flush_done=0`; `ent_xi=0`; `vld_sr=0`; `occ=0`; FIFO empty; state RUN.
- Window accepted at edge t:
  - `ent_xi` updated at t.
  - FIFO write at edge t+LATENCY+1.
  - `m_valid=1` in the cycle after, so first-data latency is LATENCY+1 edges after acceptance.
- Throughput: one window per clock sustained while `m_ready=1`. `FIFO_DEPTH ≥ LATENCY+2` guarantees no bubbles.
- Backpressure: with `m_ready=0`, `s_ready` falls in the cycle after `occ` reaches FIFO_DEPTH, so exactly FIFO_DEPTH windows are accepted. It rises in the cycle after the first pop.
- Reset mid-operation: synchronous `rst` clears `vld_sr`, `occ`, FIFO and FSM at the next edge. In-flight windows are discarded. Entity contents are don't-care because they are masked by `vld_sr`.
- Outputs stay in order; no reordering or dropping except on reset.

## Structure
- Package `filter_median_pkg`:
  - `MEDIAN_7X7_LATENCY` constant.
  - `pix_t` typedef (`logic [DWIDTH-1:0]`).
  - `ctrl_state_t` enum {RUN, DRAIN, DONE}.
  - `median_idx(KERNEL_SIZE)` function.
- One sub-module: `sync_fifo_fwft` (DWIDTH × FIFO_DEPTH, show-ahead, full/empty/count).
- The entity is instantiated by the parent next to this controller, not inside it, so 5x5 and 7x7 variants share the controller.

## Test plan
Bench setup: KERNEL_SIZE=49, DWIDTH=8, LATENCY=12, FIFO_DEPTH=16. The entity is a behavioral model: delay line plus sort.

- **Single window:** after reset, send 1 window with pixels k=0..48 as 48−k → exactly one `m_valid`, `m_data=24`, 13 edges after acceptance; `flush_done` stays 0.
- **Streaming:** send 1000 back-to-back random windows with `m_ready=1` → `s_ready` stays 1 after the first cycle; output matches the scoreboard median in order; no gaps after the first output.
- **Full stall:** hold `m_ready=0` and offer windows continuously → exactly 16 accepted; `s_ready=0` from then on. Release `m_ready` → 16 medians in order, then acceptance resumes; `ovf_err` never set.
- **Random backpressure:** `m_ready` random at 30%, `s_valid` random at 70% for 5000 windows → all medians match the scoreboard; `ovf_err` never set.
- **Flush:** pulse `flush` with 5 windows in flight → `s_ready=0` next cycle; 5 medians emerge; `flush_done` pulses once, 1 cycle after `occ` reaches 0; `s_ready=1` the cycle after. A flush on an empty pipeline → `flush_done` 2 cycles after `flush`.
- **Reset mid-stream:** assert `rst` for 1 cycle with 8 windows in flight → `m_valid=0` the following cycle; no stale medians appear later; a new window yields its correct median at 13 edges.
